// File: rtl/jk_ff_bank.sv
// jk_ff_bank: bank of WIDTH flip-flops with runtime-selectable JK/T/D/SR rules.
// Registered rise/fall pulses, SR-illegal error flags and a saturating change counter.

// Per-bit next-state rule for one flip-flop of the bank.
module jk_ff_lane (
    input  logic [1:0] mode,
    input  logic       q,
    input  logic       j,
    input  logic       k,
    output logic       q_nx
);
    typedef enum logic [1:0] {
        M_JK = 2'b00,
        M_T  = 2'b01,
        M_D  = 2'b10,
        M_SR = 2'b11
    } mode_e;

    // Next state for this bit under the selected rule; SR 11 holds the bit.
    always_comb begin
        q_nx = q;
        case (mode_e'(mode))
            M_JK: begin
                case ({j, k})
                    2'b01:   q_nx = 1'b0;
                    2'b10:   q_nx = 1'b1;
                    2'b11:   q_nx = ~q;
                    default: q_nx = q;
                endcase
            end
            M_T:  q_nx = j ? ~q : q;
            M_D:  q_nx = j;
            M_SR: begin
                case ({j, k})
                    2'b10:   q_nx = 1'b1;
                    2'b01:   q_nx = 1'b0;
                    default: q_nx = q;
                endcase
            end
            default: q_nx = q;
        endcase
    end
endmodule

module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             sr_err,
    output logic             sr_err_stk,
    output logic [CNT_W-1:0] chg_cnt
);
    logic [WIDTH-1:0] upd_nx;
    logic [WIDTH-1:0] q_nx;
    logic             sr_hit;
    logic             q_chg;
    logic             cnt_max;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            jk_ff_lane u_lane (
                .mode (mode),
                .q    (q[gi]),
                .j    (j[gi]),
                .k    (k[gi]),
                .q_nx (upd_nx[gi])
            );
        end
    endgenerate

    // Resolve clear/enable priority over the per-bit rules and flag SR misuse.
    always_comb begin
        q_nx    = q;
        if (sync_clr)
            q_nx = RESET_VAL;
        else if (en)
            q_nx = upd_nx;
        sr_hit  = en & ~sync_clr & (mode == 2'b11) & (|(j & k));
        q_chg   = (q_nx != q);
        cnt_max = &chg_cnt;
    end

    assign q_n = ~q;

    // State, edge pulses, error flags and change counter all move on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= RESET_VAL;
            q_rise     <= '0;
            q_fall     <= '0;
            sr_err     <= 1'b0;
            sr_err_stk <= 1'b0;
            chg_cnt    <= '0;
        end else begin
            q          <= q_nx;
            q_rise     <= ~q & q_nx;
            q_fall     <= q & ~q_nx;
            sr_err     <= sr_hit;
            sr_err_stk <= sync_clr ? 1'b0 : (sr_err_stk | sr_hit);
            if (sync_clr)
                chg_cnt <= '0;
            else if (q_chg && !cnt_max)
                chg_cnt <= chg_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_jk_ff_bank.sv
// Scoreboard bench for jk_ff_bank: dut_a checks reset value A5, dut_b (CNT_W=2) checks behaviour.
module tb_jk_ff_bank;
    logic       clk, rst_n, en, sync_clr;
    logic [1:0] mode;
    logic [7:0] j, k;

    logic [7:0]  qa, qna, ra, fa;
    logic        ea, sa;
    logic [15:0] ca;
    logic [7:0]  qb, qnb, rb, fb;
    logic        eb, sb_stk;
    logic [1:0]  cb;

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .mode(mode),
        .j(j), .k(k), .q(qa), .q_n(qna), .q_rise(ra), .q_fall(fa),
        .sr_err(ea), .sr_err_stk(sa), .chg_cnt(ca)
    );

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .mode(mode),
        .j(j), .k(k), .q(qb), .q_n(qnb), .q_rise(rb), .q_fall(fb),
        .sr_err(eb), .sr_err_stk(sb_stk), .chg_cnt(cb)
    );

    typedef struct {
        string      name;
        bit         sel_b;
        logic [7:0] q, rise, fall;
        logic       err, stk;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge (clock or async reset) pops one expectation if present.
    initial begin
        exp_t       e;
        logic [7:0] aq, aqn, ar, af;
        logic       ae, as_;
        int         ac;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel_b) begin
                    aq = qb; aqn = qnb; ar = rb; af = fb; ae = eb; as_ = sb_stk; ac = int'(cb);
                end else begin
                    aq = qa; aqn = qna; ar = ra; af = fa; ae = ea; as_ = sa; ac = int'(ca);
                end
                n_tests++;
                if (aq !== e.q || aqn !== ~e.q || ar !== e.rise || af !== e.fall ||
                    ae !== e.err || as_ !== e.stk || ac != e.cnt) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h q_n=%h rise=%h fall=%h err=%b stk=%b cnt=%0d, want q=%h q_n=%h rise=%h fall=%h err=%b stk=%b cnt=%0d",
                             e.name, aq, aqn, ar, af, ae, as_, ac,
                             e.q, ~e.q, e.rise, e.fall, e.err, e.stk, e.cnt);
                end
            end
        end
    end

    function automatic exp_t mk(input string nm, input bit b, input logic [7:0] eq, er, ef,
                                input logic ee, es, input int ec);
        exp_t x;
        x.name = nm; x.sel_b = b; x.q = eq; x.rise = er; x.fall = ef;
        x.err = ee; x.stk = es; x.cnt = ec;
        return x;
    endfunction

    // Drive one clocked update and queue what the next edge must produce.
    task automatic step(input string nm, input bit b, input logic e_n, c, input logic [1:0] m,
                        input logic [7:0] jj, kk, input logic [7:0] eq, er, ef,
                        input logic ee, es, input int ec);
        @(negedge clk);
        en = e_n; sync_clr = c; mode = m; j = jj; k = kk;
        sb.push_back(mk(nm, b, eq, er, ef, ee, es, ec));
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; sync_clr = 1'b0; mode = 2'b00; j = '0; k = '0;
        #2;
        sb.push_back(mk("rst_a", 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 0));
        rst_n = 1'b0;
        @(negedge clk);
        sb.push_back(mk("rst_b_held", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        //    name         b   en clr mode   j      k      q      rise   fall   err stk cnt
        step("jk_set",    1, 1, 0, 2'b00, 8'hF0, 8'h0F, 8'hF0, 8'hF0, 8'h00, 0, 0, 1);
        step("jk_toggle", 1, 1, 0, 2'b00, 8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'hF0, 0, 0, 2);
        step("clr1",      1, 1, 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 0, 0, 0);
        step("t1",        1, 1, 0, 2'b01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 0, 0, 1);
        step("t2",        1, 1, 0, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 2);
        step("t3",        1, 1, 0, 2'b01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 0, 0, 3);
        step("t4_sat",    1, 1, 0, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 3);
        step("en0_hold",  1, 0, 0, 2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 3);
        step("clr2",      1, 1, 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        step("sr_illegal",1, 1, 0, 2'b11, 8'h03, 8'h06, 8'h01, 8'h01, 8'h00, 1, 1, 1);
        step("sr_hold",   1, 1, 0, 2'b11, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 0, 1, 1);
        step("d_load",    1, 1, 0, 2'b10, 8'h04, 8'h00, 8'h04, 8'h04, 8'h01, 0, 1, 2);
        step("sr_en0",    1, 0, 0, 2'b11, 8'hFF, 8'hFF, 8'h04, 8'h00, 8'h00, 0, 1, 2);
        step("clr_sr",    1, 1, 1, 2'b11, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h04, 0, 0, 0);
        step("d_ff1",     1, 1, 0, 2'b10, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 0, 1);
        step("d_001",     1, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 2);
        step("d_ff2",     1, 1, 0, 2'b10, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 0, 3);
        step("d_sat",     1, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 3);
        step("d_ff3",     1, 1, 0, 2'b10, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 0, 3);
        step("clr_en0",   1, 0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        step("jk_set_lo", 1, 1, 0, 2'b00, 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h00, 0, 0, 1);
        step("jk_reset",  1, 1, 0, 2'b00, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h03, 0, 0, 2);
        step("jk_hold",   1, 1, 0, 2'b00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 0, 0, 2);

        // dut_a now holds AC with a nonzero count; async reset must restore A5 at once.
        @(negedge clk);
        sb.push_back(mk("rst_mid_a", 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 0));
        rst_n = 1'b0;
        @(negedge clk);
        sb.push_back(mk("rst_mid_b", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step("a_d_load",  0, 1, 0, 2'b10, 8'h3C, 8'h00, 8'h3C, 8'h18, 8'h81, 0, 0, 1);

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
